// File: rtl/variable_pkg.sv
// Shared constants, timing defaults and FSM state type for the throw scheduler.
package variable_pkg;

  localparam logic [1:0] PLAYER_1   = 2'b01;
  localparam logic [1:0] PLAYER_2   = 2'b10;
  localparam logic [2:0] TURN_FIRST = 3'd1;
  localparam logic [2:0] TURN_LAST  = 3'd7;

  localparam int TURN_TIMEOUT_DEF  = 600_000_000;
  localparam int FLIGHT_MAX_DEF    = 300_000_000;
  localparam int SETTLE_CYCLES_DEF = 30_000_000;
  localparam int CNT_W_DEF         = 30;

  typedef enum logic [2:0] {
    ARM,
    LAUNCH,
    FLIGHT,
    SETTLE,
    SWITCH
  } sched_state_e;

  // Turn numbers run 1..7 and never show 0.
  function automatic logic [2:0] next_turn(input logic [2:0] t);
    return (t == TURN_LAST) ? TURN_FIRST : t + 3'd1;
  endfunction

endpackage

// File: rtl/throw_scheduler_sched_timer.sv
// Shared cycle counter with synchronous clear, count enable and terminal-count flag.
module sched_timer #(
  parameter int CNT_W = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == limit - CNT_W'(1));

endmodule

// File: rtl/throw_scheduler.sv
// Turn arbiter for the shared throw engine: grant, launch, flight wait, settle, switch.
// Optional ARM-state turn timeout enabled by THROW_SCHEDULER_TIMEOUT_EN.
module throw_scheduler
  import variable_pkg::*;
#(
  parameter int TURN_TIMEOUT  = TURN_TIMEOUT_DEF,
  parameter int FLIGHT_MAX    = FLIGHT_MAX_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic       clk60MHz,
  input  logic       rst_n,
  input  logic       p1_throw_req,
  input  logic       p2_throw_req,
  input  logic [6:0] p1_power,
  input  logic [6:0] p2_power,
  input  logic       throw_busy,
  output logic       throw_start,
  output logic [6:0] throw_power,
  output logic [1:0] current_player,
  output logic [2:0] turn,
  output logic       forfeit
);

  sched_state_e     state, state_nx;
  logic             start_nx, forfeit_nx, seen_busy, seen_nx;
  logic [6:0]       power_nx;
  logic [1:0]       player_nx;
  logic [2:0]       turn_nx;
  logic             tmr_clr, tmr_en, tmr_tc;
  logic [CNT_W-1:0] tmr_limit;
  logic             owner_req;
  logic [6:0]       owner_power;

  assign owner_req   = (current_player == PLAYER_1) ? p1_throw_req : p2_throw_req;
  assign owner_power = (current_player == PLAYER_1) ? p1_power     : p2_power;

  // One counter serves all three delays; the active state picks its limit.
  always_comb begin
    case (state)
      ARM:     tmr_limit = CNT_W'(TURN_TIMEOUT);
      SETTLE:  tmr_limit = CNT_W'(SETTLE_CYCLES);
      default: tmr_limit = CNT_W'(FLIGHT_MAX);
    endcase
  end

  sched_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk60MHz),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .tc    (tmr_tc)
  );

  always_comb begin
    state_nx   = state;
    start_nx   = 1'b0;
    forfeit_nx = 1'b0;
    power_nx   = throw_power;
    player_nx  = current_player;
    turn_nx    = turn;
    seen_nx    = seen_busy;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    case (state)
      ARM: begin
        if (owner_req) begin
          state_nx = LAUNCH;
          power_nx = owner_power;
        end
`ifdef THROW_SCHEDULER_TIMEOUT_EN
        else if (tmr_tc) begin
          forfeit_nx = 1'b1;
          state_nx   = SWITCH;
        end
        tmr_en = 1'b1;
`else
        tmr_clr = 1'b1;
`endif
      end
      LAUNCH: begin
        start_nx = 1'b1;
        seen_nx  = 1'b0;
        tmr_clr  = 1'b1;
        state_nx = FLIGHT;
      end
      FLIGHT: begin
        if (throw_busy) seen_nx = 1'b1;
        // A completed flight outranks the watchdog expiring on the same cycle.
        if (!throw_busy && seen_busy) begin
          state_nx = SETTLE;
          tmr_clr  = 1'b1;
        end else if (tmr_tc) begin
          forfeit_nx = 1'b1;
          state_nx   = SWITCH;
        end else begin
          tmr_en = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_tc) state_nx = SWITCH;
        else        tmr_en   = 1'b1;
      end
      SWITCH: begin
        player_nx = (current_player == PLAYER_1) ? PLAYER_2 : PLAYER_1;
        turn_nx   = next_turn(turn);
        tmr_clr   = 1'b1;
        state_nx  = ARM;
      end
      default: state_nx = ARM;
    endcase
  end

  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ARM;
      throw_start    <= 1'b0;
      throw_power    <= '0;
      current_player <= PLAYER_1;
      turn           <= TURN_FIRST;
      forfeit        <= 1'b0;
      seen_busy      <= 1'b0;
    end else begin
      state          <= state_nx;
      throw_start    <= start_nx;
      throw_power    <= power_nx;
      current_player <= player_nx;
      turn           <= turn_nx;
      forfeit        <= forfeit_nx;
      seen_busy      <= seen_nx;
    end
  end

endmodule
